keypad_entry: RTL and testbench
===============================

KEYPAD_ENTRY -- requirements
Module: keypad_entry

Interface
REQ-001 SHALL have parameter NDIGITS, default 4: digits required per code (2..8).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 50_000_000: idle cycles in ENTRY before automatic clear.
REQ-003 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port kp_pressed  input  1  debounced key-held level from the debouncer stage.
REQ-006 SHALL have port kp_code  input  4  scanner key code, stable while kp_pressed is high.
REQ-007 SHALL have port code_ack  input  1  consumer accepts the presented code.
REQ-008 SHALL have port code_valid  output  1  complete code available; held until acknowledged.
REQ-009 SHALL have port code  output  4*NDIGITS  BCD digits, first-entered digit in the MSB nibble.
REQ-010 SHALL have port digit_count  output  4  digits accepted so far (0..NDIGITS).
REQ-011 SHALL have port entry_err  output  1  one-cycle pulse on a rejected action.
REQ-012 SHALL have port timeout  output  1  one-cycle pulse on inactivity clear.

Function
REQ-013 SHALL register kp_pressed and form key_evt = kp_pressed & ~kp_pressed_d; one event per press regardless of hold length.
REQ-014 SHALL sample kp_code in the key_evt cycle; the state/register update is visible on the next clock edge (1-cycle latency).
REQ-015 SHALL decode kp_code: 0x0-0x9 digit, 0xA CLEAR, 0xB ENTER, 0xC-0xF ignored (no state change, no error).
REQ-016 SHALL implement states IDLE, ENTRY, READY.
REQ-017 IDLE: digit -> code shifted left 4 with digit in LSB nibble, digit_count=1, go ENTRY; CLEAR ignored; ENTER -> entry_err pulse, stay IDLE.
REQ-018 ENTRY, digit with digit_count<NDIGITS: shift in, increment digit_count, restart idle counter.
REQ-019 ENTRY, digit with digit_count==NDIGITS: digit dropped, entry_err pulse, counter restarted, contents unchanged.
REQ-020 ENTRY, CLEAR: code=0, digit_count=0, go IDLE.
REQ-021 ENTRY, ENTER with digit_count==NDIGITS: go READY and assert code_valid the next cycle; with fewer digits: entry_err pulse, code=0, digit_count=0, go IDLE.
REQ-022 ENTRY: idle counter increments each cycle without key_evt; on reaching TIMEOUT_CYC-1 -> timeout pulse, code=0, digit_count=0, go IDLE.
REQ-023 READY: code_valid=1, code and digit_count frozen; all key events ignored without error.
REQ-024 READY with code_ack=1: next cycle code_valid=0, code=0, digit_count=0, state IDLE.
REQ-025 code_ack outside READY SHALL have no effect.
REQ-026 A key_evt in the same cycle as code_ack in READY SHALL be dropped (ack wins).
REQ-027 Idle counter width SHALL be $clog2(TIMEOUT_CYC); counter held at 0 outside ENTRY; no wrap.
REQ-028 entry_err and timeout SHALL never assert in the same cycle.

Reset
REQ-029 reset_n low SHALL asynchronously force state IDLE, code=0, digit_count=0, code_valid=0, entry_err=0, timeout=0, idle counter=0, kp_pressed_d=1.
REQ-030 A key held across reset release SHALL NOT generate key_evt (kp_pressed_d reset to 1).
REQ-031 Reset asserted in ENTRY or READY SHALL discard partial/pending code with no pulse outputs.

Structure
REQ-032 Package keypad_pkg SHALL hold KEY_CLEAR=4'hA, KEY_ENTER=4'hB and the entry state enum.
REQ-033 Edge detection SHALL be a sub-module rise_detect (clk, reset_n, level in, one-cycle pulse out, reset history=1).

Verification (NDIGITS=4, TIMEOUT_CYC=100)
REQ-034 Press 1,2,3,4,ENTER (each held 10 cycles) -> code_valid=1, code=16'h1234, digit_count=4; code_ack pulse -> code_valid=0, code=0 next cycle.
REQ-035 Press 5,6,ENTER -> entry_err single-cycle pulse, digit_count=0, state IDLE, code_valid stays 0.
REQ-036 Press 1,2,3,4,9 -> entry_err pulse on the 9, code stays 16'h1234; then CLEAR -> code=0, digit_count=0.
REQ-037 Press 7, then idle 100 cycles -> timeout pulse exactly once at idle cycle 99, code=0, digit_count=0.
REQ-038 In READY, press 8 coincident with code_ack -> IDLE, code=0, digit_count=0 (8 not captured); hold key 8 for 500 cycles in ENTRY -> digit_count increments by exactly 1.
REQ-039 Assert reset_n low after 1,2 entered with key held through release -> all outputs 0, no key_evt after release.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared key codes, entry FSM state type and key classification helper
// for the keypad code-entry block.
package keypad_pkg;

  localparam logic [3:0] KEY_CLEAR = 4'hA;
  localparam logic [3:0] KEY_ENTER = 4'hB;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ENTRY,
    ST_READY
  } entry_state_t;

  function automatic logic is_digit(input logic [3:0] key);
    return key <= 4'h9;
  endfunction

endpackage

// File: rtl/rise_detect.sv
// One-cycle pulse on a rising level. History resets high so a level already
// high when reset is released does not produce a pulse.
module rise_detect (
  input  logic clk,
  input  logic reset_n,
  input  logic level,
  output logic pulse
);

  logic level_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) level_d <= 1'b1;
    else          level_d <= level;
  end

  assign pulse = level & ~level_d;

endmodule

// File: rtl/keypad_entry.sv
// Collects NDIGITS BCD key presses into a code, presents it until acknowledged,
// and clears itself after TIMEOUT_CYC idle cycles of partial entry.
module keypad_entry
  import keypad_pkg::*;
#(
  parameter int NDIGITS     = 4,
  parameter int TIMEOUT_CYC = 50_000_000
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   kp_pressed,
  input  logic [3:0]             kp_code,
  input  logic                   code_ack,
  output logic                   code_valid,
  output logic [4*NDIGITS-1:0]   code,
  output logic [3:0]             digit_count,
  output logic                   entry_err,
  output logic                   timeout
);

  localparam int              CODE_W    = 4 * NDIGITS;
  localparam int              CW        = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0]   IDLE_LAST = CW'(TIMEOUT_CYC - 1);
  localparam logic [3:0]      FULL      = 4'(NDIGITS);

  entry_state_t        state, state_n;
  logic [CODE_W-1:0]   code_n;
  logic [3:0]          count_n;
  logic [CW-1:0]       idle_cnt, idle_n;
  logic                valid_n, err_n, to_n;
  logic                key_evt;

  rise_detect u_rise (
    .clk     (clk),
    .reset_n (reset_n),
    .level   (kp_pressed),
    .pulse   (key_evt)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      code        <= '0;
      digit_count <= '0;
      code_valid  <= 1'b0;
      entry_err   <= 1'b0;
      timeout     <= 1'b0;
      idle_cnt    <= '0;
    end else begin
      state       <= state_n;
      code        <= code_n;
      digit_count <= count_n;
      code_valid  <= valid_n;
      entry_err   <= err_n;
      timeout     <= to_n;
      idle_cnt    <= idle_n;
    end
  end

  // Every path that leaves ENTRY or READY for IDLE also clears the code,
  // so IDLE always holds an all-zero code and a shift loads the first digit.
  always_comb begin
    state_n = state;
    code_n  = code;
    count_n = digit_count;
    valid_n = code_valid;
    err_n   = 1'b0;
    to_n    = 1'b0;
    idle_n  = '0;
    case (state)
      ST_IDLE: begin
        if (key_evt && is_digit(kp_code)) begin
          code_n  = {code[CODE_W-5:0], kp_code};
          count_n = 4'd1;
          state_n = ST_ENTRY;
        end else if (key_evt && kp_code == KEY_ENTER) begin
          err_n = 1'b1;
        end
      end
      ST_ENTRY: begin
        if (key_evt && is_digit(kp_code)) begin
          if (digit_count < FULL) begin
            code_n  = {code[CODE_W-5:0], kp_code};
            count_n = digit_count + 4'd1;
          end else begin
            err_n = 1'b1;
          end
        end else if (key_evt && kp_code == KEY_CLEAR) begin
          code_n  = '0;
          count_n = '0;
          state_n = ST_IDLE;
        end else if (key_evt && kp_code == KEY_ENTER) begin
          if (digit_count == FULL) begin
            valid_n = 1'b1;
            state_n = ST_READY;
          end else begin
            err_n   = 1'b1;
            code_n  = '0;
            count_n = '0;
            state_n = ST_IDLE;
          end
        end else if (idle_cnt == IDLE_LAST) begin
          to_n    = 1'b1;
          code_n  = '0;
          count_n = '0;
          state_n = ST_IDLE;
        end else begin
          idle_n = idle_cnt + 1'b1;
        end
      end
      ST_READY: begin
        valid_n = 1'b1;
        if (code_ack) begin
          valid_n = 1'b0;
          code_n  = '0;
          count_n = '0;
          state_n = ST_IDLE;
        end
      end
      default: begin
        state_n = ST_IDLE;
        code_n  = '0;
        count_n = '0;
        valid_n = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_keypad_entry.sv
// Directed bench for keypad_entry (NDIGITS=4, TIMEOUT_CYC=100) with a code
// scoreboard and pulse monitors sampled on the falling clock edge.
module tb_keypad_entry;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        kp_pressed;
  logic [3:0]  kp_code;
  logic        code_ack;
  logic        code_valid;
  logic [15:0] code;
  logic [3:0]  digit_count;
  logic        entry_err;
  logic        timeout;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          last_evt_cyc = 0;
  int          err_cnt = 0;
  int          err_run = 0;
  int          to_cnt = 0;
  int          to_run = 0;
  int          to_cyc = 0;
  int          err_base, to_base;
  logic        valid_prev = 1'b0;
  logic [15:0] popped;
  logic [15:0] exp_q[$];

  keypad_entry #(.NDIGITS(4), .TIMEOUT_CYC(100)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .kp_pressed  (kp_pressed),
    .kp_code     (kp_code),
    .code_ack    (code_ack),
    .code_valid  (code_valid),
    .code        (code),
    .digit_count (digit_count),
    .entry_err   (entry_err),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Called on a falling edge; the key event is taken on the next rising edge.
  task automatic applyStimulus(input logic [3:0] key, input int hold);
    kp_code      = key;
    kp_pressed   = 1'b1;
    last_evt_cyc = cyc + 1;
    repeat (hold) @(negedge clk);
    kp_pressed = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // Scoreboard and pulse monitors.
  always @(negedge clk) begin
    if (reset_n) begin
      if (code_valid && !valid_prev) begin
        if (exp_q.size() == 0) checkOutput("sb_unexpected_valid", 32'd1, 32'd0);
        else begin
          popped = exp_q.pop_front();
          checkOutput("sb_code", 32'(code), 32'(popped));
        end
      end
      if (entry_err && timeout) checkOutput("err_and_timeout", 32'd1, 32'd0);
      if (entry_err) begin
        if (err_run == 0) err_cnt++;
        err_run++;
      end else if (err_run != 0) begin
        checkOutput("err_width", 32'(err_run), 32'd1);
        err_run = 0;
      end
      if (timeout) begin
        if (to_run == 0) begin
          to_cnt++;
          to_cyc = cyc;
        end
        to_run++;
      end else if (to_run != 0) begin
        checkOutput("timeout_width", 32'(to_run), 32'd1);
        to_run = 0;
      end
    end
    valid_prev = code_valid;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset_n    = 1'b0;
    kp_pressed = 1'b0;
    kp_code    = 4'h0;
    code_ack   = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_valid", 32'(code_valid), 32'd0);
    checkOutput("rst_code", 32'(code), 32'd0);
    checkOutput("rst_count", 32'(digit_count), 32'd0);
    checkOutput("rst_pulses", 32'({entry_err, timeout}), 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] full code entry and acknowledge");
    err_base = err_cnt;
    applyStimulus(4'h1, 10);
    applyStimulus(4'h2, 10);
    applyStimulus(4'h3, 10);
    applyStimulus(4'h4, 10);
    checkOutput("entry_count4", 32'(digit_count), 32'd4);
    checkOutput("entry_code", 32'(code), 32'h1234);
    exp_q.push_back(16'h1234);
    applyStimulus(4'hB, 10);
    checkOutput("ready_valid", 32'(code_valid), 32'd1);
    checkOutput("ready_count", 32'(digit_count), 32'd4);
    applyStimulus(4'h5, 10);
    checkOutput("ready_key_ignored", 32'(code), 32'h1234);
    checkOutput("ready_no_err", 32'(err_cnt - err_base), 32'd0);
    code_ack = 1'b1;
    @(negedge clk);
    code_ack = 1'b0;
    checkOutput("ack_valid", 32'(code_valid), 32'd0);
    checkOutput("ack_code", 32'(code), 32'd0);
    checkOutput("ack_count", 32'(digit_count), 32'd0);

    $display("[TB] short code entered");
    err_base = err_cnt;
    applyStimulus(4'h5, 10);
    applyStimulus(4'h6, 10);
    applyStimulus(4'hB, 10);
    checkOutput("short_err", 32'(err_cnt - err_base), 32'd1);
    checkOutput("short_count", 32'(digit_count), 32'd0);
    checkOutput("short_code", 32'(code), 32'd0);
    checkOutput("short_valid", 32'(code_valid), 32'd0);

    $display("[TB] overflow digit then clear");
    err_base = err_cnt;
    applyStimulus(4'h1, 10);
    applyStimulus(4'h2, 10);
    applyStimulus(4'h3, 10);
    applyStimulus(4'h4, 10);
    applyStimulus(4'h9, 10);
    checkOutput("over_err", 32'(err_cnt - err_base), 32'd1);
    checkOutput("over_code", 32'(code), 32'h1234);
    checkOutput("over_count", 32'(digit_count), 32'd4);
    applyStimulus(4'hA, 10);
    checkOutput("clear_code", 32'(code), 32'd0);
    checkOutput("clear_count", 32'(digit_count), 32'd0);

    $display("[TB] inactivity timeout");
    to_base = to_cnt;
    applyStimulus(4'h7, 10);
    checkOutput("to_entry_code", 32'(code), 32'h0007);
    checkOutput("to_entry_count", 32'(digit_count), 32'd1);
    for (int i = 0; i < 200 && to_cnt == to_base; i++) @(negedge clk);
    repeat (20) @(negedge clk);
    checkOutput("to_pulses", 32'(to_cnt - to_base), 32'd1);
    checkOutput("to_latency", 32'(to_cyc - last_evt_cyc), 32'd100);
    checkOutput("to_code", 32'(code), 32'd0);
    checkOutput("to_count", 32'(digit_count), 32'd0);

    $display("[TB] key coincident with ack, long hold");
    err_base = err_cnt;
    applyStimulus(4'h4, 10);
    applyStimulus(4'h3, 10);
    applyStimulus(4'h2, 10);
    applyStimulus(4'h1, 10);
    exp_q.push_back(16'h4321);
    applyStimulus(4'hB, 10);
    checkOutput("ack2_ready", 32'(code_valid), 32'd1);
    kp_code    = 4'h8;
    kp_pressed = 1'b1;
    code_ack   = 1'b1;
    @(negedge clk);
    code_ack = 1'b0;
    repeat (5) @(negedge clk);
    kp_pressed = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("ackwin_valid", 32'(code_valid), 32'd0);
    checkOutput("ackwin_code", 32'(code), 32'd0);
    checkOutput("ackwin_count", 32'(digit_count), 32'd0);
    to_base = to_cnt;
    applyStimulus(4'h1, 10);
    kp_code    = 4'h8;
    kp_pressed = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("hold_count_early", 32'(digit_count), 32'd2);
    checkOutput("hold_code", 32'(code), 32'h0018);
    repeat (88) @(negedge clk);
    checkOutput("hold_count_late", 32'(digit_count), 32'd2);
    repeat (410) @(negedge clk);
    kp_pressed = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("hold_timeout", 32'(to_cnt - to_base), 32'd1);
    checkOutput("hold_count_end", 32'(digit_count), 32'd0);
    checkOutput("hold_no_err", 32'(err_cnt - err_base), 32'd0);

    $display("[TB] ignored keys, stray ack, reset with key held");
    err_base = err_cnt;
    applyStimulus(4'hA, 10);
    checkOutput("idle_clear_count", 32'(digit_count), 32'd0);
    applyStimulus(4'h1, 10);
    applyStimulus(4'hC, 10);
    checkOutput("ignored_count", 32'(digit_count), 32'd1);
    code_ack = 1'b1;
    @(negedge clk);
    code_ack = 1'b0;
    @(negedge clk);
    checkOutput("stray_ack_count", 32'(digit_count), 32'd1);
    checkOutput("stray_ack_valid", 32'(code_valid), 32'd0);
    applyStimulus(4'h2, 10);
    checkOutput("pre_rst_code", 32'(code), 32'h0012);
    kp_code    = 4'h5;
    kp_pressed = 1'b1;
    reset_n    = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst2_code", 32'(code), 32'd0);
    checkOutput("rst2_count", 32'(digit_count), 32'd0);
    checkOutput("rst2_flags", 32'({code_valid, entry_err, timeout}), 32'd0);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    checkOutput("held_no_evt_count", 32'(digit_count), 32'd0);
    checkOutput("held_no_evt_code", 32'(code), 32'd0);
    kp_pressed = 1'b0;
    repeat (2) @(negedge clk);
    applyStimulus(4'h3, 10);
    checkOutput("post_rst_code", 32'(code), 32'h0003);
    checkOutput("post_rst_count", 32'(digit_count), 32'd1);
    checkOutput("rst_seq_no_err", 32'(err_cnt - err_base), 32'd0);

    checkOutput("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
